hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//  Sequences the ID->EXE pipeline registers: detects RAW hazards between the instruction in ID and the
//  destinations in EXE/MEM, drives freeze (hold PC + IF/ID reg), flush_id (bubble into ID stage regs) and
//  flush_if (squash IF/ID) on taken branches. Sits beside the ID stage, feeding its flush input and IF freeze.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles flush_if/flush_id stay asserted per taken branch (>=1)
//  MAX_STALL     15  consecutive freeze cycles tolerated before stall_err sets (>=1)
//  CNT_W         16  width of stall_count
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  id_valid     in   1      ID holds a real instruction
//  src1         in   4      Rn index;  src1_valid in 1: instruction reads Rn
//  src2         in   4      Rm/Rd index; two_src in 1: instruction reads src2
//  exe_dst      in   4      EXE destination; exe_wb_en in 1; exe_mem_r_en in 1 (EXE is a load)
//  mem_dst      in   4      MEM destination; mem_wb_en in 1
//  branch_taken in   1      taken branch resolved in EXE this cycle
//  freeze       out  1      hold PC and IF/ID register
//  flush_id     out  1      load bubble into ID stage registers
//  flush_if     out  1      squash IF/ID register
//  state        out  2      00 RUN, 01 STALL, 10 BRFLUSH
//  stall_count  out  CNT_W  total freeze cycles, saturating at all-ones
//  stall_err    out  1      sticky: freeze held > MAX_STALL consecutive cycles
// BEHAVIOUR
//  - Reset (rst=0, async): state=RUN, counters=0, stall_err=0; freeze/flush_id/flush_if forced 0 while rst=0.
//  - match(r) = (exe_wb_en & exe_dst==r) | (mem_wb_en & mem_dst==r)   [see CONFIGURATION]
//  - hazard = id_valid & ((src1_valid & match(src1)) | (two_src & match(src2)))   (combinational)
//  - brf = branch_taken | (state==BRFLUSH)
//  - Outputs, same cycle (combinational from state + inputs): flush_if=brf; freeze=hazard & ~brf;
//    flush_id=hazard | brf. Branch wins over hazard: hazarding instruction is squashed, not held.
//  - FSM (registered): RUN->BRFLUSH on branch_taken if FLUSH_CYCLES>1, flush_cnt<=FLUSH_CYCLES-1;
//    RUN->STALL on hazard & ~branch_taken; STALL->RUN when ~hazard; STALL->BRFLUSH/RUN on branch_taken as RUN;
//    BRFLUSH: flush_cnt decrements, ->RUN when flush_cnt==1 & ~branch_taken; branch_taken reloads
//    flush_cnt<=FLUSH_CYCLES-1 (stays BRFLUSH). FLUSH_CYCLES=1: branch flushes its own cycle only, no BRFLUSH.
//  - stall_run: +1 each cycle freeze=1, cleared when freeze=0; stall_err<=1 at edge where stall_run
//    reaches MAX_STALL while freeze=1 (i.e. on the (MAX_STALL+1)th consecutive freeze cycle); only rst clears it.
//  - stall_count: +1 per freeze cycle, holds at 2^CNT_W-1.
//  - Register index 4'd0 is a valid register (no zero-register exemption); id_valid=0 never stalls.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: forwarding unit present; match(r) = exe_wb_en & exe_mem_r_en & exe_dst==r
//    (only load-use stalls; MEM-stage and EXE ALU results never stall).
//  Not defined: match(r) as in BEHAVIOUR (any pending EXE or MEM write stalls).
// TESTING
//  1 no-fwd: exe_wb_en=1 exe_dst=3, src1=3 src1_valid=1 id_valid=1 -> freeze=1 flush_id=1 flush_if=0,
//    state=STALL next edge; drop exe_wb_en -> freeze=0, state=RUN, stall_count=1.
//  2 hazard + branch_taken same cycle -> freeze=0 flush_if=1 flush_id=1; stall_count unchanged.
//  3 FLUSH_CYCLES=3, 1-cycle branch_taken pulse -> flush_if=1 for exactly 3 cycles (state BRFLUSH 2 of them);
//    second pulse during BRFLUSH -> 3 more cycles from the new pulse.
//  4 MAX_STALL=4, hazard held 6 cycles -> stall_err=1 after 5th freeze edge, stays 1 after hazard drops.
//  5 HAZARD_FORWARDING_EN: mem_wb_en=1 mem_dst=7 src2=7 two_src=1 -> freeze=0; exe_mem_r_en=1 exe_dst=7
//    -> freeze=1. Without macro: MEM case -> freeze=1.
//  6 rst low mid-BRFLUSH (async, between edges) -> outputs 0 immediately, state=RUN, stall_count=0,
//    stall_err=0; release -> normal operation next edge.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_flush_ctrl
//
// Purpose:
//   Sequences the ID->EXE pipeline registers. Detects read-after-write hazards
//   between the instruction in ID and the destinations pending in EXE/MEM, and
//   squashes the front end on taken branches.
//     freeze   : hold PC and the IF/ID register (hazard, no branch)
//     flush_id : inject a bubble into the ID stage registers
//     flush_if : squash the IF/ID register (taken branch, FLUSH_CYCLES long)
//   A branch wins over a hazard. The hazarding instruction is on the wrong
//   path, so it is squashed rather than held.
//
// Configuration macro:
//   HAZARD_FORWARDING_EN
//     Defined    : a forwarding unit is present. Only a load in EXE can stall.
//     Undefined  : any pending EXE or MEM register write stalls.
//
// Parameters:
//   FLUSH_CYCLES  cycles flush_if/flush_id stay high per taken branch (>=1)
//   MAX_STALL     consecutive freeze cycles tolerated before stall_err (>=1)
//   CNT_W         width of stall_count
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   id_valid       ID holds a real instruction
//   src1/src1_valid, src2/two_src   source registers read by the ID instruction
//   exe_dst/exe_wb_en/exe_mem_r_en  EXE destination, write enable, is-load
//   mem_dst/mem_wb_en               MEM destination, write enable
//   branch_taken   taken branch resolved in EXE this cycle
//   freeze, flush_id, flush_if      pipeline control, combinational
//   state          00 RUN, 01 STALL, 10 BRFLUSH
//   stall_count    total freeze cycles, saturating at all-ones
//   stall_err      sticky: freeze held longer than MAX_STALL consecutive cycles
// -----------------------------------------------------------------------------
module hazard_flush_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic             src1_valid,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dst,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dst,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  output logic             freeze,
  output logic             flush_id,
  output logic             flush_if,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_err
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_STALL   = 2'b01,
    ST_BRFLUSH = 2'b10
  } state_e;

  // The flush counter only needs to hold FLUSH_CYCLES-1.
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RUN_W = $clog2(MAX_STALL + 1);

  localparam logic [FC_W-1:0]  FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FLUSH_LAST   = FC_W'(1);
  localparam logic [RUN_W-1:0] RUN_LIMIT    = RUN_W'(MAX_STALL);

  state_e            state_q, state_nxt;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_nxt;
  logic [RUN_W-1:0]  stall_run_q;
  logic [CNT_W-1:0]  stall_count_q;
  logic              stall_err_q;

  logic              match1, match2;
  logic              hazard;
  logic              brf;

  // ---------------------------------------------------------------------------
  // Hazard detection. Register 0 is an ordinary register.
  // ---------------------------------------------------------------------------
`ifdef HAZARD_FORWARDING_EN
  // EXE ALU results and MEM results are forwarded. Only load data, which is
  // not available until MEM, forces a stall.
  logic exe_load;
  assign exe_load = exe_wb_en & exe_mem_r_en;
  assign match1   = exe_load & (exe_dst == src1);
  assign match2   = exe_load & (exe_dst == src2);

  // The MEM-stage write port has no effect on stalling in this build.
  logic unused_mem_port;
  assign unused_mem_port = mem_wb_en ^ (^mem_dst);
`else
  assign match1 = (exe_wb_en & (exe_dst == src1)) | (mem_wb_en & (mem_dst == src1));
  assign match2 = (exe_wb_en & (exe_dst == src2)) | (mem_wb_en & (mem_dst == src2));

  // Without forwarding, a load stalls like any other write.
  logic unused_exe_mem_r_en;
  assign unused_exe_mem_r_en = exe_mem_r_en;
`endif

  assign hazard = id_valid & ((src1_valid & match1) | (two_src & match2));
  assign brf    = branch_taken | (state_q == ST_BRFLUSH);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      flush_cnt_q <= flush_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state_q;
    flush_cnt_nxt = flush_cnt_q;
    if (branch_taken) begin
      // A branch in any state (re)starts the flush window. A one-cycle flush
      // is entirely covered by branch_taken itself.
      if (FLUSH_CYCLES > 1) begin
        state_nxt     = ST_BRFLUSH;
        flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt     = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) state_nxt = ST_STALL;
        end
        ST_STALL: begin
          if (!hazard) state_nxt = ST_RUN;
        end
        ST_BRFLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_nxt     = ST_RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt_q - FLUSH_LAST;
          end
        end
        default: begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. These are combinational from the state and inputs, and are
  // forced low for as long as reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_if = rst & brf;
    freeze   = rst & hazard & ~brf;
    flush_id = rst & (hazard | brf);
  end

  // ---------------------------------------------------------------------------
  // Stall statistics
  // ---------------------------------------------------------------------------
  // stall_run counts consecutive freeze cycles. It saturates at MAX_STALL, and
  // a further freeze cycle at that point sets stall_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_run_q   <= '0;
      stall_err_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      if (freeze) begin
        if (stall_run_q == RUN_LIMIT) begin
          stall_err_q <= 1'b1;
        end else begin
          stall_run_q <= stall_run_q + 1'b1;
        end
        if (stall_count_q != '1) begin
          stall_count_q <= stall_count_q + 1'b1;
        end
      end else begin
        stall_run_q <= '0;
      end
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_flush_ctrl
//
// Directed vectors for hazard_flush_ctrl, built with FLUSH_CYCLES=3,
// MAX_STALL=4 and CNT_W=4. The driver applies one input vector per cycle at
// the falling edge and queues the hand-computed expected outputs. A monitor
// samples the DUT 2 ns later and compares the sample against the head of the
// queue. Registered fields (state, stall_count, stall_err) are the values
// left by the previous rising edges.
// -----------------------------------------------------------------------------
module tb_hazard_flush_ctrl;

  localparam int FC = 3;
  localparam int MS = 4;
  localparam int CW = 4;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] STL = 2'b01;
  localparam logic [1:0] BRF = 2'b10;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [3:0]    src1;
  logic          src1_valid;
  logic [3:0]    src2;
  logic          two_src;
  logic [3:0]    exe_dst;
  logic          exe_wb_en;
  logic          exe_mem_r_en;
  logic [3:0]    mem_dst;
  logic          mem_wb_en;
  logic          branch_taken;
  logic          freeze;
  logic          flush_id;
  logic          flush_if;
  logic [1:0]    state;
  logic [CW-1:0] stall_count;
  logic          stall_err;

  hazard_flush_ctrl #(
    .FLUSH_CYCLES(FC),
    .MAX_STALL   (MS),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .src1        (src1),
    .src1_valid  (src1_valid),
    .src2        (src2),
    .two_src     (two_src),
    .exe_dst     (exe_dst),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dst     (mem_dst),
    .mem_wb_en   (mem_wb_en),
    .branch_taken(branch_taken),
    .freeze      (freeze),
    .flush_id    (flush_id),
    .flush_if    (flush_if),
    .state       (state),
    .stall_count (stall_count),
    .stall_err   (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [3:0] src1;
    logic       src1_valid;
    logic [3:0] src2;
    logic       two_src;
    logic [3:0] exe_dst;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] mem_dst;
    logic       mem_wb_en;
    logic       branch_taken;
  } stim_t;

  typedef struct {
    string         name;
    logic          fr;
    logic          fid;
    logic          fif;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  me;
  stim_t s;
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic stim_t idle();
    stim_t v;
    v     = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  // Load in EXE writing r3, and the ID instruction reads r3 as Rn.
  // This stalls with or without forwarding.
  function automatic stim_t load_hz();
    stim_t v;
    v              = idle();
    v.id_valid     = 1'b1;
    v.src1         = 4'd3;
    v.src1_valid   = 1'b1;
    v.exe_dst      = 4'd3;
    v.exe_wb_en    = 1'b1;
    v.exe_mem_r_en = 1'b1;
    return v;
  endfunction

  task automatic cyc(input string name, input logic fr, input logic fid, input logic fif,
                     input logic [1:0] st, input int cnt, input logic err);
    exp_t e;
    @(negedge clk);
    rst          = s.rst;
    id_valid     = s.id_valid;
    src1         = s.src1;
    src1_valid   = s.src1_valid;
    src2         = s.src2;
    two_src      = s.two_src;
    exe_dst      = s.exe_dst;
    exe_wb_en    = s.exe_wb_en;
    exe_mem_r_en = s.exe_mem_r_en;
    mem_dst      = s.mem_dst;
    mem_wb_en    = s.mem_wb_en;
    branch_taken = s.branch_taken;
    e.name = name;
    e.fr   = fr;
    e.fid  = fid;
    e.fif  = fif;
    e.st   = st;
    e.cnt  = CW'(cnt);
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each queued expectation with the DUT sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        me = exp_q.pop_front();
        vectors++;
        if (freeze !== me.fr || flush_id !== me.fid || flush_if !== me.fif ||
            state !== me.st || stall_count !== me.cnt || stall_err !== me.err) begin
          miscompares++;
          $display("FAIL %s: got fr=%b fid=%b fif=%b st=%0d cnt=%0d err=%b, want fr=%b fid=%b fif=%b st=%0d cnt=%0d err=%b",
                   me.name, freeze, flush_id, flush_if, state, stall_count, stall_err,
                   me.fr, me.fid, me.fif, me.st, me.cnt, me.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s = load_hz();
    s.rst = 1'b0;
    rst = 1'b0; id_valid = 1'b0; src1 = '0; src1_valid = 1'b0; src2 = '0; two_src = 1'b0;
    exe_dst = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dst = '0; mem_wb_en = 1'b0;
    branch_taken = 1'b0;

    // Reset held: a live hazard must not reach the outputs.
    cyc("reset_hold", 0, 0, 0, RUN, 0, 0);
    s = idle();                 cyc("reset_release", 0, 0, 0, RUN, 0, 0);
    s = load_hz(); s.id_valid = 1'b0;
    cyc("no_id_valid", 0, 0, 0, RUN, 0, 0);

    // Basic load-use stall and recovery.
    s = load_hz();              cyc("raw_stall", 1, 1, 0, RUN, 0, 0);
    s = load_hz(); s.exe_wb_en = 1'b0;
    cyc("raw_clear", 0, 0, 0, STL, 1, 0);
    s = idle();                 cyc("back_run", 0, 0, 0, RUN, 1, 0);

    // Register 0 hazard via src2, then the same match with two_src low.
    s = idle(); s.id_valid = 1'b1; s.two_src = 1'b1; s.exe_wb_en = 1'b1; s.exe_mem_r_en = 1'b1;
    cyc("r0_src2", 1, 1, 0, RUN, 1, 0);
    s.two_src = 1'b0;           cyc("src2_unused", 0, 0, 0, STL, 2, 0);

    // Hazard and branch in the same cycle: squash, no freeze, count unchanged.
    s = load_hz(); s.branch_taken = 1'b1;
    cyc("hz_and_br", 0, 1, 1, RUN, 2, 0);
    s = load_hz();              cyc("brflush_over_hz", 0, 1, 1, BRF, 2, 0);
    s = idle();                 cyc("brflush_last", 0, 1, 1, BRF, 2, 0);
    s = idle();                 cyc("brflush_done", 0, 0, 0, RUN, 2, 0);

    // Three-cycle flush, then a second pulse re-arms it from inside BRFLUSH.
    s = idle(); s.branch_taken = 1'b1;
    cyc("br_pulse", 0, 1, 1, RUN, 2, 0);
    s = idle();                 cyc("br_f2", 0, 1, 1, BRF, 2, 0);
    s = idle(); s.branch_taken = 1'b1;
    cyc("br_repulse", 0, 1, 1, BRF, 2, 0);
    s = idle();                 cyc("br_re_f2", 0, 1, 1, BRF, 2, 0);
    s = idle();                 cyc("br_re_f3", 0, 1, 1, BRF, 2, 0);
    s = idle();                 cyc("br_re_done", 0, 0, 0, RUN, 2, 0);

    // Hazard held 6 cycles: stall_err is visible only after the 5th freeze edge.
    s = load_hz();              cyc("long_1", 1, 1, 0, RUN, 2, 0);
    s = load_hz();              cyc("long_2", 1, 1, 0, STL, 3, 0);
    s = load_hz();              cyc("long_3", 1, 1, 0, STL, 4, 0);
    s = load_hz();              cyc("long_4", 1, 1, 0, STL, 5, 0);
    s = load_hz();              cyc("long_5", 1, 1, 0, STL, 6, 0);
    s = load_hz();              cyc("long_6_err", 1, 1, 0, STL, 7, 1);
    s = idle();                 cyc("err_sticky", 0, 0, 0, STL, 8, 1);
    s = idle();                 cyc("err_sticky_run", 0, 0, 0, RUN, 8, 1);

    // stall_count saturates at 15 (CW=4).
    for (int i = 0; i < 9; i++) begin
      s = load_hz();
      cyc("sat", 1, 1, 0, (i == 0) ? RUN : STL, (8 + i > 15) ? 15 : 8 + i, 1);
    end
    s = idle();                 cyc("sat_hold", 0, 0, 0, STL, 15, 1);
    s = idle();                 cyc("sat_run", 0, 0, 0, RUN, 15, 1);

    // Forwarding-dependent cases: a MEM write, an EXE ALU write, then an EXE load.
    s = idle(); s.id_valid = 1'b1; s.src2 = 4'd7; s.two_src = 1'b1; s.mem_dst = 4'd7; s.mem_wb_en = 1'b1;
    cyc("mem_dep", !FWD, !FWD, 0, RUN, 15, 1);
    s = idle(); s.id_valid = 1'b1; s.src2 = 4'd7; s.two_src = 1'b1; s.exe_dst = 4'd7; s.exe_wb_en = 1'b1;
    cyc("exe_alu_dep", !FWD, !FWD, 0, FWD ? RUN : STL, 15, 1);
    s.exe_mem_r_en = 1'b1;      cyc("exe_load_dep", 1, 1, 0, FWD ? RUN : STL, 15, 1);
    s = idle();                 cyc("dep_clear", 0, 0, 0, STL, 15, 1);

    // Asynchronous reset mid-BRFLUSH, then normal operation resumes.
    s = idle(); s.branch_taken = 1'b1;
    cyc("pre_rst_br", 0, 1, 1, RUN, 15, 1);
    s = idle();                 cyc("pre_rst_brf", 0, 1, 1, BRF, 15, 1);
    s = load_hz(); s.branch_taken = 1'b1; s.rst = 1'b0;
    cyc("async_rst", 0, 0, 0, RUN, 0, 0);
    s = load_hz();              cyc("post_rst_stall", 1, 1, 0, RUN, 0, 0);
    s = idle();                 cyc("post_rst_count", 0, 0, 0, STL, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
